rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/a3/wd3) between the in-order pipeline writeback stage and a multi-cycle result source (MDU or load miss return).
- Primary writeback has fixed priority and is never stalled by this block. Multi-cycle results are buffered in a small FIFO and drained into idle port cycles.
- Keeps a pending-destination scoreboard for the hazard unit, and raises a stall request when a buffered result starves.

---
 rtl/rf_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/rf_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-port arbiter and the
// buffer that sits in front of it.
//   REG_W  : register address width
//   XLEN   : data width
//   NREGS  : number of architectural registers (x0 is hard-wired zero)
//   wb_entry_t : one buffered multi-cycle result {rd, data}
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // True when the destination is a real register (x0 writes are dropped).
  function automatic logic is_real_rd(input logic [REG_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of wb_entry_t with a registered occupancy count.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push       : write push_data at the edge (ignored when full)
//   push_data  : entry to write
//   pop        : drop the head entry at the edge (ignored when empty)
//   head       : current oldest entry (valid when !empty)
//   full/empty : registered occupancy flags
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// Push and pop in the same cycle leave the count unchanged.
// ---------------------------------------------------------------------------
module sync_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset: entries are only observed through the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port between the in-order
// writeback stage (fixed priority, never stalled here) and a multi-cycle
// result source whose results are buffered and drained into idle cycles.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   wb_we/wb_rd/wb_data : primary writeback
//   mc_valid/mc_rd/mc_data, mc_ready : multi-cycle result handshake
//   issue_valid/issue_rd: multi-cycle op issued, marks its rd pending
//   we3/a3/wd3          : register-file write port
//   pending             : per-register outstanding multi-cycle write
//   stall_req           : ask the pipeline to bubble writeback next cycle
//
// Handshake: a result transfers at the edge when mc_valid && mc_ready.
// mc_ready depends on registered occupancy only, so it never relies on a
// same-cycle pop; the producer may hold mc_valid with stable payload until
// it sees mc_ready. Results addressed to x0 are accepted and discarded.
// ---------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             mc_valid,
  input  logic [REG_W-1:0] mc_rd,
  input  logic [XLEN-1:0]  mc_data,
  output logic             mc_ready,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  output logic             we3,
  output logic [REG_W-1:0] a3,
  output logic [XLEN-1:0]  wd3,
  output logic [NREGS-1:0] pending,
  output logic             stall_req
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_entry_t head;
  wb_entry_t push_entry;
  logic      fifo_full;
  logic      fifo_empty;
  logic      prim;
  logic      push;
  logic      pop;

  logic [CW-1:0]    starve_cnt;
  logic [NREGS-1:0] pending_next;

  // -------------------------------------------------------------------------
  // Result buffer
  // -------------------------------------------------------------------------
  assign mc_ready        = !fifo_full;
  assign push            = mc_valid && mc_ready && is_real_rd(mc_rd);
  assign push_entry.rd   = mc_rd;
  assign push_entry.data = mc_data;

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // -------------------------------------------------------------------------
  // Port selection: primary first, then the buffer head, else idle.
  // Kept combinational so the regfile's write-first bypass still sees the
  // primary write in its own cycle.
  // -------------------------------------------------------------------------
  assign prim = wb_we && is_real_rd(wb_rd);
  assign pop  = !reset && !prim && !fifo_empty;

  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (!reset) begin
      if (prim) begin
        we3 = 1'b1;
        a3  = wb_rd;
        wd3 = wb_data;
      end else if (!fifo_empty) begin
        we3 = 1'b1;
        a3  = head.rd;
        wd3 = head.data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pending scoreboard. The buffer pop is the only clearer; an issue to the
  // same register in the same cycle is a newer write and must stay visible.
  // -------------------------------------------------------------------------
  always_comb begin
    pending_next = pending;
    if (pop) begin
      pending_next[head.rd] = 1'b0;
    end
    if (issue_valid && is_real_rd(issue_rd)) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  // -------------------------------------------------------------------------
  // Starvation: count cycles the head is blocked by primary traffic.
  // stall_req rises the cycle after the count has sat at STARVE_MAX and is
  // held until the head finally drains.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if (prim && (starve_cnt != CW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CW'(1);
      end

      if (fifo_empty || pop) begin
        stall_req <= 1'b0;
      end else if (starve_cnt == CW'(STARVE_MAX)) begin
        stall_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pending;
  logic        stall_req;

  logic [36:0] exp_q[$];
  logic [36:0] exp_e;
  int          n_cmp;
  int          n_fail;

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .mc_valid    (mc_valid),
    .mc_rd       (mc_rd),
    .mc_data     (mc_data),
    .mc_ready    (mc_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .we3         (we3),
    .a3          (a3),
    .wd3         (wd3),
    .pending     (pending),
    .stall_req   (stall_req)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle_inputs();
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic drive_prim(input logic [4:0] rd, input logic [31:0] d);
    wb_we = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  task automatic drive_mc(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mc_valid = v; mc_rd = rd; mc_data = d;
  endtask

  // tests
  task automatic test_reset();
    @(negedge clk); reset = 1'b1; drive_prim(5'd7, 32'h1234); #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3_forced: got %b want 0", we3); end
    @(negedge clk); reset = 1'b0; idle_inputs(); #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3: got %b want 0", we3); end
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", pending); end
    n_cmp++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mc_ready: got %b want 1", mc_ready); end
    n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
    n_cmp++; if ({a3, wd3} !== 37'h0) begin n_fail++; $display("FAIL reset_a3_wd3: got %h/%h want 0/0", a3, wd3); end
  endtask

  task automatic test_latency();
    @(negedge clk); idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd5; #1;
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL lat_pend_c0: got %h want 0", pending); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); issue_valid = 1'b0;
      if (c == 3) begin
        drive_mc(1'b1, 5'd5, 32'hDEADBEEF);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
      end else begin
        drive_mc(1'b0, 5'd0, 32'h0);
      end
      #1;
      n_cmp++; if (pending[5] !== 1'b1) begin n_fail++; $display("FAIL lat_pend_c%0d: got %b want 1", c, pending[5]); end
      if (c < 4) begin
        n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL lat_idle_c%0d: we3 got %b want 0", c, we3); end
      end else begin
        exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
        n_cmp++; if ({we3, a3, wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL lat_write: got %b/%0d/%h want 1/%0d/%h", we3, a3, wd3, exp_e[36:32], exp_e[31:0]); end
      end
    end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL lat_pend_c5: got %h want 0", pending); end
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL lat_after: we3 got %b want 0", we3); end
  endtask

  task automatic test_starvation();
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk); idle_inputs(); drive_prim(5'd7, 32'h11);
      if (k == 0) begin
        drive_mc(1'b1, 5'd9, 32'h9999_0009);
        exp_q.push_back({5'd9, 32'h9999_0009});
      end
      #1;
      n_cmp++; if ({we3, a3, wd3} !== {1'b1, 5'd7, 32'h11}) begin n_fail++; $display("FAIL starve_prim_k%0d: got %b/%0d/%h want 1/7/11", k, we3, a3, wd3); end
      n_cmp++; if (stall_req !== (k == 5)) begin n_fail++; $display("FAIL starve_stall_k%0d: got %b want %b", k, stall_req, (k == 5)); end
    end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_bubble_stall: got %b want 1", stall_req); end
    exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
    n_cmp++; if ({we3, a3, wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL starve_bubble_write: got %b/%0d/%h want 1/%0d/%h", we3, a3, wd3, exp_e[36:32], exp_e[31:0]); end
    @(negedge clk); #1;
    n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_drop: got %b want 0", stall_req); end
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL starve_idle: we3 got %b want 0", we3); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); idle_inputs(); drive_prim(5'd7, 32'h22);
      drive_mc(1'b1, (i < 4) ? 5'(i + 1) : 5'd5, 32'h100 + i + 1);
      #1;
      n_cmp++; if (mc_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready_i%0d: got %b want %b", i, mc_ready, (i < 4)); end
      if (i < 4) exp_q.push_back({mc_rd, mc_data});
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); idle_inputs(); #1;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
      n_cmp++; if ({we3, a3, wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL fill_order_j%0d: got %b/%0d/%h want 1/%0d/%h", j, we3, a3, wd3, exp_e[36:32], exp_e[31:0]); end
    end
    @(negedge clk); #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL fill_drained: we3 got %b want 0", we3); end
    n_cmp++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after: got %b want 1", mc_ready); end
  endtask

  task automatic test_x0();
    @(negedge clk); idle_inputs(); drive_prim(5'd0, 32'hBAD); drive_mc(1'b1, 5'd0, 32'hBAD0); #1;
    n_cmp++; if ({we3, a3, wd3} !== 38'h0) begin n_fail++; $display("FAIL x0_port: got %b/%0d/%h want 0/0/0", we3, a3, wd3); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL x0_not_enqueued: we3 got %b want 0", we3); end
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL x0_pending: got %h want 0", pending); end
    // three real results, one discarded x0, then a fourth real result
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle_inputs(); drive_prim(5'd7, 32'h33);
      drive_mc(1'b1, (i == 3) ? 5'd0 : 5'(10 + i), 32'h200 + i);
      #1;
      if (i == 4) begin
        n_cmp++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL x0_count_kept: mc_ready got %b want 1", mc_ready); end
      end
      if (mc_rd != 5'd0) exp_q.push_back({mc_rd, mc_data});
    end
    @(negedge clk); idle_inputs(); drive_prim(5'd7, 32'h33); #1;
    n_cmp++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL x0_full: mc_ready got %b want 0", mc_ready); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); idle_inputs(); #1;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
      n_cmp++; if ({we3, a3, wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL x0_order_j%0d: got %b/%0d/%h want 1/%0d/%h", j, we3, a3, wd3, exp_e[36:32], exp_e[31:0]); end
    end
    @(negedge clk); #1;
    n_cmp++; if ({we3, pending} !== 33'h0) begin n_fail++; $display("FAIL x0_end: we3 %b pending %h want 0/0", we3, pending); end
  endtask

  task automatic test_set_wins_and_reset();
    @(negedge clk); idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd3; #1;
    @(negedge clk); idle_inputs(); drive_mc(1'b1, 5'd3, 32'h3333); exp_q.push_back({5'd3, 32'h3333}); #1;
    n_cmp++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL sw_pend_set: got %b want 1", pending[3]); end
    @(negedge clk); idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd3; #1;
    exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : 37'h0;
    n_cmp++; if ({we3, a3, wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL sw_write: got %b/%0d/%h want 1/%0d/%h", we3, a3, wd3, exp_e[36:32], exp_e[31:0]); end
    @(negedge clk); idle_inputs(); #1;
    n_cmp++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL sw_set_wins: got %b want 1", pending[3]); end
    // buffer two results behind primary traffic, then reset
    @(negedge clk); idle_inputs(); drive_prim(5'd7, 32'h44); drive_mc(1'b1, 5'd20, 32'h2020);
    issue_valid = 1'b1; issue_rd = 5'd20; #1;
    @(negedge clk); idle_inputs(); drive_prim(5'd7, 32'h44); drive_mc(1'b1, 5'd21, 32'h2121);
    issue_valid = 1'b1; issue_rd = 5'd21; #1;
    @(negedge clk); idle_inputs(); drive_prim(5'd7, 32'h44); reset = 1'b1; #1;
    n_cmp++; if (pending !== 32'h0030_0008) begin n_fail++; $display("FAIL rst_pend_before: got %h want 00300008", pending); end
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL rst_we3: got %b want 0", we3); end
    @(negedge clk); reset = 1'b0; idle_inputs(); #1;
    n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL rst_no_write: we3 got %b want 0", we3); end
    n_cmp++; if (pending !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %h want 0", pending); end
    n_cmp++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mc_ready: got %b want 1", mc_ready); end
  endtask

  task automatic test_random();
    logic [4:0]  p_rd;
    logic [31:0] p_d;
    logic        p_we;
    int          drain;
    for (int cyc = 0; cyc < 400 + 20; cyc++) begin
      @(negedge clk); idle_inputs();
      if (cyc < 400) begin
        p_we = !stall_req && ($urandom_range(0, 99) < 55);
        p_rd = 5'($urandom_range(0, 31));
        p_d  = $urandom;
        wb_we = p_we; wb_rd = p_rd; wb_data = p_d;
        drive_mc($urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), $urandom);
      end else begin
        p_we = 1'b0; p_rd = '0; p_d = '0;
      end
      #1;
      n_cmp++; if (mc_ready !== (exp_q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready_c%0d: got %b want %b", cyc, mc_ready, (exp_q.size() < DEPTH)); end
      if (p_we && p_rd != 5'd0) begin
        n_cmp++; if ({we3, a3, wd3} !== {1'b1, p_rd, p_d}) begin n_fail++; $display("FAIL rnd_prim_c%0d: got %b/%0d/%h want 1/%0d/%h", cyc, we3, a3, wd3, p_rd, p_d); end
      end else if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        n_cmp++; if ({we3, a3, wd3} !== {1'b1, exp_e}) begin n_fail++; $display("FAIL rnd_mc_c%0d: got %b/%0d/%h want 1/%0d/%h", cyc, we3, a3, wd3, exp_e[36:32], exp_e[31:0]); end
      end else begin
        n_cmp++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_c%0d: we3 got %b want 0", cyc, we3); end
      end
      if (mc_valid && (exp_q.size() < DEPTH || (p_we && p_rd != 0) == 1'b0) && mc_ready && mc_rd != 5'd0)
        exp_q.push_back({mc_rd, mc_data});
    end
    drain = exp_q.size();
    n_cmp++; if (drain != 0) begin n_fail++; $display("FAIL rnd_drain: %0d results never written, want 0", drain); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_latency();
    test_starvation();
    test_fill();
    test_x0();
    test_set_wins_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
